// File: rtl/bitfusion_sweep_checker_if.sv
// Operand/psum link between the sweep checker and the PE under test, plus the checker's control and status.
// The checker drives the master side; the PE and the host sit on the slave side.
interface bitfusion_sweep_checker_if;
  logic        start;
  logic [3:0]  pe_in;
  logic [3:0]  pe_weight;
  logic [2:0]  pe_in_width;
  logic [2:0]  pe_weight_width;
  logic        pe_s_in;
  logic        pe_s_weight;
  logic [7:0]  pe_psum;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic        fail_valid;
  logic [3:0]  fail_mode;
  logic [3:0]  fail_in;
  logic [3:0]  fail_weight;
  logic [7:0]  fail_psum;

  modport master (
    input  start, pe_psum,
    output pe_in, pe_weight, pe_in_width, pe_weight_width, pe_s_in, pe_s_weight,
           busy, done, pass, err_count, fail_valid, fail_mode, fail_in, fail_weight, fail_psum
  );

  modport slave (
    output start, pe_psum,
    input  pe_in, pe_weight, pe_in_width, pe_weight_width, pe_s_in, pe_s_weight,
           busy, done, pass, err_count, fail_valid, fail_mode, fail_in, fail_weight, fail_psum
  );
endinterface

// File: rtl/bitfusion_sweep_checker.sv
// Self-test sweeper: drives every operand pair of each enabled PE mode and checks psum against a golden product.
// Each vector takes SETTLE+1 cycles; start is ignored while busy, and the PE cannot stall the sweep.
module bitfusion_sweep_checker #(
  parameter int unsigned SETTLE    = 2,
  parameter logic [8:0]  MODE_MASK = 9'h1FF
) (
  input logic                       clk,
  input logic                       rst_n,
  bitfusion_sweep_checker_if.master sweep
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_e;
  localparam logic [3:0] NO_MODE = 4'd9;

  function automatic logic [2:0] mode_in_w(input logic [3:0] m);
    case (m)
      4'd0:                   return 3'd1;
      4'd1, 4'd3, 4'd6, 4'd8: return 3'd2;
      default:                return 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] mode_wt_w(input logic [3:0] m);
    case (m)
      4'd0:                   return 3'd1;
      4'd1, 4'd4, 4'd7, 4'd8: return 3'd2;
      default:                return 3'd4;
    endcase
  endfunction

  function automatic logic mode_sg(input logic [3:0] m);
    return m >= 4'd5;
  endfunction

  // Operands are kept as their driven w-bit pattern; signed sweeps start at the pattern of -2^(w-1).
  function automatic logic [3:0] op_min(input logic [2:0] w, input logic s);
    case (w)
      3'd1:    return s ? 4'd1 : 4'd0;
      3'd2:    return s ? 4'd2 : 4'd0;
      default: return s ? 4'd8 : 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] op_max(input logic [2:0] w, input logic s);
    case (w)
      3'd1:    return s ? 4'd0 : 4'd1;
      3'd2:    return s ? 4'd1 : 4'd3;
      default: return s ? 4'd7 : 4'd15;
    endcase
  endfunction

  function automatic logic [3:0] op_inc(input logic [3:0] v, input logic [2:0] w);
    case (w)
      3'd1:    return {3'b000, ~v[0]};
      3'd2:    return {2'b00, v[1:0] + 2'd1};
      default: return v + 4'd1;
    endcase
  endfunction

  function automatic logic [7:0] ext(input logic [3:0] v, input logic [2:0] w, input logic s);
    case (w)
      3'd1:    return {{7{s & v[0]}}, v[0]};
      3'd2:    return {{6{s & v[1]}}, v[1:0]};
      default: return {{4{s & v[3]}}, v};
    endcase
  endfunction

  function automatic logic [3:0] first_en(input logic [3:0] lo);
    logic [3:0] r;
    r = NO_MODE;
    for (int k = 8; k >= 0; k--) begin
      if (MODE_MASK[k] && k >= int'(lo)) r = 4'(k);
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  mode_q, mode_d, in_q, in_d, wt_q, wt_d, cnt_q, cnt_d;
  logic [2:0]  inw_q, inw_d, wtw_q, wtw_d;
  logic        sin_q, sin_d, swt_q, swt_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0] err_q, err_d;
  logic        fv_q, fv_d;
  logic [3:0]  fmode_q, fmode_d, fin_q, fin_d, fwt_q, fwt_d;
  logic [7:0]  fpsum_q, fpsum_d;
  logic [3:0]  load_mode;
  logic        load;
  logic [7:0]  golden;
  logic        last_a, last_b;

  assign golden = ext(in_q, inw_q, sin_q) * ext(wt_q, wtw_q, swt_q);
  assign last_a = (in_q == op_max(inw_q, sin_q));
  assign last_b = (wt_q == op_max(wtw_q, swt_q));

  always_comb begin
    state_d = state_q;  mode_d  = mode_q;  in_d    = in_q;    wt_d    = wt_q;
    cnt_d   = cnt_q;    inw_d   = inw_q;   wtw_d   = wtw_q;   sin_d   = sin_q;
    swt_d   = swt_q;    busy_d  = busy_q;  done_d  = done_q;  pass_d  = pass_q;
    err_d   = err_q;    fv_d    = fv_q;    fmode_d = fmode_q; fin_d   = fin_q;
    fwt_d   = fwt_q;    fpsum_d = fpsum_q;
    load      = 1'b0;
    load_mode = mode_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (sweep.start) begin
          err_d   = '0;   fv_d   = 1'b0; fmode_d = '0;   fin_d = '0;
          fwt_d   = '0;   fpsum_d = '0;  done_d  = 1'b0; pass_d = 1'b0;
          load_mode = first_en(4'd0);
          if (load_mode == NO_MODE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            load    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (sweep.pe_psum != golden) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (!fv_q) begin
            fv_d    = 1'b1;
            fmode_d = mode_q;
            fin_d   = in_q;
            fwt_d   = wt_q;
            fpsum_d = sweep.pe_psum;
          end
        end
        state_d = ST_SETTLE;
        if (!last_b) begin
          wt_d = op_inc(wt_q, wtw_q);
        end else if (!last_a) begin
          wt_d = op_min(wtw_q, swt_q);
          in_d = op_inc(in_q, inw_q);
        end else begin
          // Last vector of this mode: the PE outputs hold it if no further mode is enabled.
          load_mode = first_en(mode_q + 4'd1);
          if (load_mode == NO_MODE) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 16'd0);
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      mode_d = load_mode;
      inw_d  = mode_in_w(load_mode);
      wtw_d  = mode_wt_w(load_mode);
      sin_d  = mode_sg(load_mode);
      swt_d  = mode_sg(load_mode);
      in_d   = op_min(mode_in_w(load_mode), mode_sg(load_mode));
      wt_d   = op_min(mode_wt_w(load_mode), mode_sg(load_mode));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE; mode_q <= '0;    in_q   <= '0;    wt_q    <= '0;
      cnt_q   <= '0;      inw_q  <= 3'd4;  wtw_q  <= 3'd4;  sin_q   <= 1'b0;
      swt_q   <= 1'b0;    busy_q <= 1'b0;  done_q <= 1'b0;  pass_q  <= 1'b0;
      err_q   <= '0;      fv_q   <= 1'b0;  fmode_q <= '0;   fin_q   <= '0;
      fwt_q   <= '0;      fpsum_q <= '0;
    end else begin
      state_q <= state_d; mode_q <= mode_d; in_q   <= in_d;   wt_q    <= wt_d;
      cnt_q   <= cnt_d;   inw_q  <= inw_d;  wtw_q  <= wtw_d;  sin_q   <= sin_d;
      swt_q   <= swt_d;   busy_q <= busy_d; done_q <= done_d; pass_q  <= pass_d;
      err_q   <= err_d;   fv_q   <= fv_d;   fmode_q <= fmode_d; fin_q <= fin_d;
      fwt_q   <= fwt_d;   fpsum_q <= fpsum_d;
    end
  end

  assign sweep.pe_in           = in_q;
  assign sweep.pe_weight       = wt_q;
  assign sweep.pe_in_width     = inw_q;
  assign sweep.pe_weight_width = wtw_q;
  assign sweep.pe_s_in         = sin_q;
  assign sweep.pe_s_weight     = swt_q;
  assign sweep.busy            = busy_q;
  assign sweep.done            = done_q;
  assign sweep.pass            = pass_q;
  assign sweep.err_count       = err_q;
  assign sweep.fail_valid      = fv_q;
  assign sweep.fail_mode       = fmode_q;
  assign sweep.fail_in         = fin_q;
  assign sweep.fail_weight     = fwt_q;
  assign sweep.fail_psum       = fpsum_q;
endmodule
